// File: rtl/rain_meas_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rain_meas_ctrl_pkg
//  Description : Shared definitions for the rain-gauge measure/send sequencer.
//                It holds the state encoding, the rank codes and the default
//                timing constants, plus a small helper used to size the
//                interval timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rain_meas_ctrl_pkg;

  // State encoding (3-bit)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_FLUSH   = 3'd4;
  localparam logic [2:0] ST_WAIT    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_CLEAR   = ST_CLEAR,
    S_MEASURE = ST_MEASURE,
    S_SEND    = ST_SEND,
    S_FLUSH   = ST_FLUSH,
    S_WAIT    = ST_WAIT
  } state_e;

  // Operating rank codes
  localparam logic [1:0] RANK_MANUAL = 2'd0;
  localparam logic [1:0] RANK_SEMI   = 2'd1;
  localparam logic [1:0] RANK_AUTO   = 2'd2;
  localparam logic [1:0] RANK_OFF    = 2'd3;

  // Default timing (50 MHz clock, 1 ms tick)
  localparam int unsigned DEF_TICK_DIV     = 50000;
  localparam int unsigned DEF_PERIOD_UNIT  = 1000;
  localparam int unsigned DEF_MEAS_TIMEOUT = 2000;
  localparam int unsigned DEF_SEND_TIMEOUT = 100;

  // Synchronizer depth for the asynchronous operator/measurement inputs
  localparam int unsigned SYNC_STAGES = 2;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rain_meas_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : rain_meas_ctrl_sync_edge
//  Description : Two-flop synchronizer for an asynchronous input, followed
//                by one history flop that yields single-cycle rise and fall
//                pulses of the synchronized level.
//  Ports       : clk_i    - system clock
//                rst_ni   - asynchronous active-low reset
//                d_i      - raw asynchronous input
//                level_o  - synchronized level
//                rise_o   - one-cycle pulse on synchronized 0->1
//                fall_o   - one-cycle pulse on synchronized 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module rain_meas_ctrl_sync_edge
  import rain_meas_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // Bits [SYNC_STAGES-1:0] are the synchronizer chain; the top bit holds the
  // previous synchronized sample for edge detection.
  logic [SYNC_STAGES:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-1:0], d_i};
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  =  sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
  assign fall_o  = ~sync_q[SYNC_STAGES-1] &  sync_q[SYNC_STAGES];

endmodule
`default_nettype wire

// File: rtl/rain_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rain_meas_ctrl
//  Description : Sequencer for the rain-gauge measure/send datapath. Runs
//                manual, semi-automatic or automatic measurement cycles:
//                clear the datapath, enable counting until a frequency pulse
//                completes, wait for the serial frame, flush the counter and
//                optionally wait for the next period.
//  Ports       : clk_i         - system clock
//                rst_ni        - asynchronous active-low reset
//                rank_i[1:0]   - 0 manual, 1 semi-auto, 2 auto, 3 disabled
//                level_i[2:0]  - period / run-length select (N = level+1)
//                control_i     - raw operator button (asynchronous)
//                freq_i        - raw measurement pulse (asynchronous)
//                send_done_i   - one-cycle pulse, frame shifted out
//                meas_en_o     - datapath enable
//                finish_send_o - datapath counter clear
//                link_rst_o    - datapath/sender reset, active-high
//                busy_o        - sequencer not idle
//                err_o         - sticky timeout flag
//                runs_left_o   - remaining semi-auto cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module rain_meas_ctrl
  import rain_meas_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned PERIOD_UNIT  = DEF_PERIOD_UNIT,
  parameter int unsigned MEAS_TIMEOUT = DEF_MEAS_TIMEOUT,
  parameter int unsigned SEND_TIMEOUT = DEF_SEND_TIMEOUT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] rank_i,
  input  logic [2:0] level_i,
  input  logic       control_i,
  input  logic       freq_i,
  input  logic       send_done_i,
  output logic       meas_en_o,
  output logic       finish_send_o,
  output logic       link_rst_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [2:0] runs_left_o
);

  localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Longest interval ever timed is the rank-2 period with level 7 (8 units).
  localparam int unsigned TMR_MAX = max3(MEAS_TIMEOUT, SEND_TIMEOUT, 8 * PERIOD_UNIT);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic trig;
  logic ctrl_level;
  logic ctrl_fall;
  logic freq_level;
  logic freq_rise;
  logic freq_fall;

  rain_meas_ctrl_sync_edge u_sync_control (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .d_i     (control_i),
    .level_o (ctrl_level),
    .rise_o  (trig),
    .fall_o  (ctrl_fall)
  );

  rain_meas_ctrl_sync_edge u_sync_freq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .d_i     (freq_i),
    .level_o (freq_level),
    .rise_o  (freq_rise),
    .fall_o  (freq_fall)
  );

  logic unused_sync;
  assign unused_sync = ctrl_level ^ ctrl_fall ^ freq_level ^ freq_rise;

  // --------------------------------------------------------------------------
  // Free-running tick divider
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;

  assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State, interval timer and status registers
  // --------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_q, err_d;
  logic [2:0]        runs_left_q, runs_left_d;
  logic              meas_en_q, finish_send_q, link_rst_q, busy_q;

  logic [TMR_W-1:0]  wait_units;
  logic [TMR_W-1:0]  wait_target;

  // Rank 2 waits N period units, rank 1 a single unit between runs.
  assign wait_units  = (rank_i == RANK_AUTO) ? (TMR_W'(level_i) + TMR_W'(1)) : TMR_W'(1);
  assign wait_target = wait_units * TMR_W'(PERIOD_UNIT);

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    runs_left_d = runs_left_q;

    case (state_q)
      S_IDLE: begin
        if ((rank_i == RANK_AUTO) ||
            (((rank_i == RANK_MANUAL) || (rank_i == RANK_SEMI)) && trig)) begin
          state_d     = S_CLEAR;
          err_d       = 1'b0;
          runs_left_d = (rank_i == RANK_SEMI) ? level_i : 3'd0;
        end
      end

      S_CLEAR: begin
        state_d = S_MEASURE;
      end

      S_MEASURE: begin
        // A synchronized fall implies the previous sample was high, and that
        // sample was taken either in MEASURE or on entry to it, so every fall
        // seen here is a complete pulse. Completion outranks the timeout.
        if (freq_fall) begin
          state_d = S_SEND;
        end else if (timer_q >= TMR_W'(MEAS_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_FLUSH;
        end
      end

      S_SEND: begin
        if (send_done_i) begin
          state_d = S_FLUSH;
        end else if (timer_q >= TMR_W'(SEND_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        state_d = S_IDLE;
        if (rank_i == RANK_AUTO) begin
          state_d = S_WAIT;
        end else if ((rank_i == RANK_SEMI) && (runs_left_q != 3'd0)) begin
          state_d     = S_WAIT;
          runs_left_d = runs_left_q - 3'd1;
        end
      end

      S_WAIT: begin
        if ((rank_i == RANK_MANUAL) || (rank_i == RANK_OFF)) begin
          state_d = S_IDLE;
        end else if (timer_q >= wait_target) begin
          state_d = S_CLEAR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The timer restarts on every state change so each state times from entry;
  // it counts ticks, hence ±1 tick resolution on every interval.
  always_comb begin
    timer_d = timer_q;
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      timer_d = '0;
    end else if (tick) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      err_q       <= 1'b0;
      runs_left_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      runs_left_q <= runs_left_d;
    end
  end

  // Outputs are registered from the next state, so they line up with the
  // state register while staying glitch-free toward the datapath.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meas_en_q     <= 1'b0;
      finish_send_q <= 1'b0;
      link_rst_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      meas_en_q     <= (state_d == S_MEASURE) || (state_d == S_SEND) || (state_d == S_FLUSH);
      finish_send_q <= (state_d == S_FLUSH);
      link_rst_q    <= (state_d == S_CLEAR);
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign meas_en_o     = meas_en_q;
  assign finish_send_o = finish_send_q;
  assign link_rst_o    = link_rst_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign runs_left_o   = runs_left_q;

endmodule
`default_nettype wire

// File: tb/tb_rain_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rain_meas_ctrl
//  Description : Self-checking bench for rain_meas_ctrl. Random run lengths,
//                levels and send delays; expectations come from the operating
//                rules (latencies, pulse counts, interval windows in ticks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rain_meas_ctrl;

  localparam int unsigned TD   = 4;   // clk cycles per tick
  localparam int unsigned PU   = 5;   // ticks per period unit
  localparam int unsigned MTO  = 30;  // measure timeout, ticks
  localparam int unsigned STO  = 10;  // send timeout, ticks

  logic       clk;
  logic       rst_n;
  logic [1:0] rank;
  logic [2:0] level;
  logic       control;
  logic       freq;
  logic       send_done;
  logic       meas_en_o;
  logic       finish_send_o;
  logic       link_rst_o;
  logic       busy_o;
  logic       err_o;
  logic [2:0] runs_left_o;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int n_clr = 0;
  int n_fin = 0;

  rain_meas_ctrl #(
    .TICK_DIV     (TD),
    .PERIOD_UNIT  (PU),
    .MEAS_TIMEOUT (MTO),
    .SEND_TIMEOUT (STO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rank_i        (rank),
    .level_i       (level),
    .control_i     (control),
    .freq_i        (freq),
    .send_done_i   (send_done),
    .meas_en_o     (meas_en_o),
    .finish_send_o (finish_send_o),
    .link_rst_o    (link_rst_o),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .runs_left_o   (runs_left_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (link_rst_o)    n_clr++;
    if (finish_send_o) n_fin++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_win(input int v, input int t);
    return (v >= t - int'(TD)) && (v <= t + int'(TD) + 2);
  endfunction

  task automatic wait_clr(input string tag, input int budget, output int at);
    int k = 0;
    while (link_rst_o !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk(tag, link_rst_o, 1'b1);
    at = cyc;
  endtask

  task automatic wait_fin(input string tag, input int budget, output int at);
    int k = 0;
    while (finish_send_o !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk(tag, finish_send_o, 1'b1);
    at = cyc;
  endtask

  // Operator press from idle: CLEAR must appear exactly 3 edges after the edge.
  task automatic start_trig(input string tag);
    control = 1'b1;
    step();
    step();
    chk({tag, "_early"}, link_rst_o, 1'b0);
    step();
    chk({tag, "_clr"}, link_rst_o, 1'b1);
    chk({tag, "_men0"}, meas_en_o, 1'b0);
    control = 1'b0;
  endtask

  // From CLEAR: run MEASURE until the freq pulse completes; ends on SEND entry.
  // A send_done is offered on the last MEASURE cycle and must be ignored.
  task automatic meas_phase(input int hi_len);
    step();
    chk("meas_entry", {link_rst_o, meas_en_o, busy_o}, 3'b011);
    freq = 1'b1;
    repeat (hi_len) step();
    freq = 1'b0;
    step();
    step();
    send_done = 1'b1;
    step();
    send_done = 1'b0;
    chk("send_no_fin", {finish_send_o, meas_en_o}, 2'b01);
  endtask

  task automatic send_phase(input int d);
    repeat (d) step();
    send_done = 1'b1;
    step();
    send_done = 1'b0;
    chk("flush_fin", {finish_send_o, meas_en_o, link_rst_o}, 3'b110);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, fl, k, lv, t;
    rst_n = 1'b0; rank = 2'd3; level = 3'd0;
    control = 1'b0; freq = 1'b0; send_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {meas_en_o, finish_send_o, link_rst_o, busy_o, err_o, runs_left_o}, 0);
    rst_n = 1'b1;
    step();
    chk("rst_idle", busy_o, 1'b0);

    // ---- Manual runs
    for (int i = 0; i < 3; i++) begin
      c0 = n_clr; c1 = n_fin;
      rank = 2'd0; level = 3'($urandom_range(0, 7));
      if (i == 1) begin
        freq = 1'b1;              // high before MEASURE entry
        repeat (3) step();
      end
      start_trig("man");
      meas_phase(int'($urandom_range(1, 20)));
      send_phase(int'($urandom_range(0, 10)));
      step();
      chk("man_idle", {busy_o, meas_en_o, finish_send_o, link_rst_o, err_o}, 0);
      chk("man_nclr", n_clr - c0, 1);
      chk("man_nfin", n_fin - c1, 1);
      rank = 2'd3;
      repeat (4) step();
    end

    // ---- Semi-automatic: level+1 runs, one period unit between them
    lv = int'($urandom_range(1, 3));
    rank = 2'd1; level = 3'(lv);
    c0 = n_clr;
    start_trig("semi");
    chk("semi_load", runs_left_o, 3'(lv));
    for (int i = 0; i <= lv; i++) begin
      meas_phase(int'($urandom_range(1, 10)));
      send_phase(int'($urandom_range(0, 5)));
      fl = cyc;
      chk("semi_rl_flush", runs_left_o, 3'(lv - i));
      if (i < lv) begin
        wait_clr("semi_wait_clr", int'(PU * TD) + 20, t);
        chk("semi_period", in_win(t - fl, int'(PU * TD)), 1'b1);
        chk("semi_rl_dec", runs_left_o, 3'(lv - i - 1));
      end else begin
        step();
        chk("semi_done", busy_o, 1'b0);
      end
    end
    chk("semi_nclr", n_clr - c0, 32'(lv + 1));
    rank = 2'd3;
    repeat (4) step();

    // ---- Automatic: repeats with N period units between FLUSH and CLEAR
    lv = int'($urandom_range(0, 2));
    rank = 2'd2; level = 3'(lv);
    step();
    chk("auto_start", link_rst_o, 1'b1);
    for (int i = 0; i < 2; i++) begin
      meas_phase(int'($urandom_range(1, 10)));
      send_phase(int'($urandom_range(0, 5)));
      fl = cyc;
      if (i == 0) begin
        wait_clr("auto_wait_clr", (lv + 1) * int'(PU * TD) + 20, t);
        chk("auto_period", in_win(t - fl, (lv + 1) * int'(PU * TD)), 1'b1);
      end
    end
    step();
    chk("auto_wait_busy", {busy_o, meas_en_o}, 2'b10);
    k = int'($urandom_range(1, 10));
    repeat (k) step();
    rank = 2'd0;
    step();
    chk("auto_stop_idle", busy_o, 1'b0);
    c0 = n_clr;
    repeat (80) step();
    chk("auto_no_clr", n_clr - c0, 0);

    // ---- Measure timeout: freq never pulses
    rank = 2'd0;
    start_trig("mto");
    c0 = cyc;
    wait_fin("mto_fin", int'(MTO * TD) + 20, t);
    chk("mto_time", in_win(t - c0, int'(MTO * TD)), 1'b1);
    chk("mto_err", err_o, 1'b1);
    step();
    chk("mto_idle", {busy_o, err_o}, 2'b01);
    start_trig("mto_retry");
    chk("mto_err_clr", err_o, 1'b0);
    meas_phase(int'($urandom_range(1, 10)));
    send_phase(int'($urandom_range(0, 5)));
    step();
    chk("mto_retry_ok", {busy_o, err_o}, 2'b00);

    // ---- Send stall, with an extra press while busy
    c0 = n_clr;
    start_trig("sto");
    meas_phase(int'($urandom_range(1, 10)));
    c1 = cyc;
    control = 1'b1;
    repeat (3) step();
    control = 1'b0;
    wait_fin("sto_fin", int'(STO * TD) + 20, t);
    chk("sto_time", in_win(t - c1, int'(STO * TD)), 1'b1);
    chk("sto_err", err_o, 1'b1);
    step();
    chk("sto_idle", busy_o, 1'b0);
    chk("sto_nclr", n_clr - c0, 1);
    repeat (4) step();

    // ---- Asynchronous reset in SEND
    start_trig("rst");
    meas_phase(int'($urandom_range(1, 10)));
    step();
    c1 = n_fin;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {meas_en_o, finish_send_o, link_rst_o, busy_o, err_o, runs_left_o}, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();
    chk("rst_release", {busy_o, meas_en_o, link_rst_o}, 0);
    chk("rst_no_fin", n_fin - c1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rain_meas_ctrl.md
# rain_meas_ctrl

Sequencer for the rain-gauge measure/send datapath. Selects manual, semi-automatic or automatic operation and drives the datapath's `en`, `finish_send` and `rst` inputs so each frequency-pulse measurement runs, is transmitted, and is cleared. Sits between the operator-side inputs (rank, level, control button) and the measurement/serial-send block; observes the conditioned `freq` input and the sender's completion pulse.

## Interface
- `TICK_DIV`, 50000: clk cycles per scheduling tick (1 ms at 50 MHz).
- `PERIOD_UNIT`, 1000: ticks per level step of the repeat period.
- `MEAS_TIMEOUT`, 2000: ticks allowed in MEASURE before abort.
- `SEND_TIMEOUT`, 100: ticks allowed in SEND before abort.

- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rank` in 2: 0 manual, 1 semi-auto, 2 auto, 3 disabled.
- `level` in 3: period/run-length select, N = level+1.
- `control` in 1: raw operator button, asynchronous.
- `freq` in 1: raw measurement pulse, asynchronous; same signal the datapath counts.
- `send_done` in 1: one-cycle pulse from sender, frame shifted out.
- `meas_en` out 1: datapath `en`.
- `finish_send` out 1: datapath counter clear.
- `link_rst` out 1: datapath/sender `rst`, active-high.
- `busy` out 1: high in any state except IDLE.
- `err` out 1: sticky timeout flag.
- `runs_left` out 3: remaining semi-auto cycles.

## Operation
- `control` and `freq`: 2-flop synchronizers; `control` rising edge → one-cycle `trig`.
- Free-running tick counter 0..TICK_DIV-1, `tick` pulse at wrap; all timeouts/periods count ticks.
- States: IDLE, CLEAR, MEASURE, SEND, FLUSH, WAIT.
- IDLE: outputs low. Start: rank 0/1 on `trig`; rank 2 immediately. On start `err` cleared; rank 1 loads `runs_left` = level (further cycles after this one).
- CLEAR: `link_rst`=1 for exactly one cycle → MEASURE, tick-based timer reset.
- MEASURE: `meas_en`=1. Completion = synced `freq` falling edge after ≥1 high sample seen in this state → SEND. Timer reaching MEAS_TIMEOUT → set `err`, → FLUSH.
- SEND: `meas_en`=1, waits `send_done` → FLUSH. SEND_TIMEOUT → `err`, → FLUSH.
- FLUSH: `finish_send`=1, `meas_en`=1, one cycle. Then: rank 0 → IDLE; rank 1 → WAIT if `runs_left`>0 (decrement on exit) else IDLE; rank 2 → WAIT; rank 3 → IDLE.
- WAIT: timer to N·PERIOD_UNIT ticks (rank 2) or PERIOD_UNIT ticks (rank 1), then CLEAR. Rank change to 0 or 3 during WAIT → IDLE.
- `trig` while busy: ignored. `rank` sampled only at IDLE exit and in FLUSH/WAIT; changes elsewhere take effect at next FLUSH.
- `send_done` outside SEND ignored.

## Timing
- Reset: state IDLE; all outputs 0; `err` 0; counters 0. Reset mid-cycle aborts immediately; no FLUSH issued.
- `trig` → CLEAR: 3 cycles after raw `control` edge (2 sync + edge register); `link_rst` next cycle, `meas_en` the cycle after.
- `freq` fall → SEND: 3 cycles; SEND → FLUSH the cycle after `send_done`.
- `freq` already high on MEASURE entry counts as seen-high.
- Timeout resolution ±1 tick; timeout and completion in same cycle: completion wins.
- Rank 2 period measured from FLUSH to next CLEAR.

## Structure
- Shared package: state encoding (3-bit localparams), rank codes, default timing constants.
- One sub-module natural: `sync_edge` (2-flop sync + rising/falling pulse), instantiated for `control` and `freq`.
- Tick divider and timer inline.

## Test plan
- Manual: rank 0, `control` pulse, `freq` high 20 cycles then low, `send_done` 10 cycles later → one `link_rst` pulse, `meas_en` high through SEND, one `finish_send`, return IDLE, `err`=0.
- Semi-auto: rank 1, level 2, TICK_DIV 4, PERIOD_UNIT 5 → exactly 3 measure cycles, WAIT 20 clocks between, `runs_left` 2→1→0.
- Auto: rank 2, level 1 → cycles repeat with 2·PERIOD_UNIT ticks WAIT; rank to 0 during WAIT → IDLE, no further CLEAR.
- Timeout: `freq` held low, MEAS_TIMEOUT 3 → `err`=1, FLUSH pulse, IDLE; next `trig` clears `err`.
- Send stall: no `send_done` → `err` after SEND_TIMEOUT ticks; extra `trig` during busy ignored.
- Reset mid-SEND → all outputs 0 asynchronously, no `finish_send`, IDLE after release.
